// File: rtl/rom_ctrl_pkg.sv
// Shared widths, fetch step and queue entry type for the ROM fetch/data arbiter.
// Types only; no logic, no latency.
package rom_ctrl_pkg;
  localparam int DEF_ADDR_W   = 10;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_FAIR_MAX = 4;
  localparam int PC_STEP      = 4;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] pc;
    logic [DEF_DATA_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/rom_fetch_arbiter_fetch_queue.sv
// Two-entry FIFO of fetched {pc, instr}; head visible the cycle after push.
// Push and pop may coincide at any occupancy; flush empties on the next edge.
module fetch_queue
  import rom_ctrl_pkg::*;
(
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);
  fetch_entry_t mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;

  assign head  = mem[rd_ptr];
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/rom_fetch_arbiter.sv
// Shares one combinational ROM port between PC fetch (into a 2-deep queue) and data reads.
// Fetch word visible 1 cycle later, data response 1 cycle after grant; fetch stalls when queue full.
module rom_fetch_arbiter
  import rom_ctrl_pkg::*;
#(
  parameter int                  ADDR_W   = DEF_ADDR_W,
  parameter int                  DATA_W   = DEF_DATA_W,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0,
  parameter int                  FAIR_MAX = DEF_FAIR_MAX
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              dreq_valid,
  input  logic [ADDR_W-1:0] dreq_addr,
  output logic              dreq_ready,
  output logic              drsp_valid,
  output logic [DATA_W-1:0] drsp_data
);
  localparam int FW = $clog2(FAIR_MAX + 1);

  logic [ADDR_W-1:0] pc;
  logic [FW-1:0]     fair_cnt;
  fetch_entry_t      head;
  fetch_entry_t      wdata;
  logic              q_full, q_empty;
  logic              pop, fetch_possible, data_grant, fetch_grant;

  // A redirect hides the head so nothing stale is consumed while the queue is being flushed.
  assign inst_valid     = !q_empty && !redirect_valid;
  assign pop            = inst_valid && inst_ready;
  assign fetch_possible = !redirect_valid && (!q_full || pop);
  assign data_grant     = dreq_valid && !((fair_cnt == FW'(FAIR_MAX)) && fetch_possible);
  assign fetch_grant    = !data_grant && fetch_possible;

  assign dreq_ready = data_grant;
  assign rom_addr   = data_grant ? {dreq_addr[ADDR_W-1:2], 2'b00} : pc;
  assign wdata      = '{pc: pc, instr: rom_data};
  assign inst_data  = head.instr;
  assign inst_pc    = head.pc;

  fetch_queue u_queue (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (fetch_grant),
    .pop     (pop),
    .flush   (redirect_valid),
    .wdata   (wdata),
    .head    (head),
    .full    (q_full),
    .empty   (q_empty)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc         <= RESET_PC;
      fair_cnt   <= '0;
      drsp_valid <= 1'b0;
      drsp_data  <= '0;
    end else begin
      if (redirect_valid)   pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
      else if (fetch_grant) pc <= pc + ADDR_W'(PC_STEP);

      if (!dreq_valid || fetch_grant)                     fair_cnt <= '0;
      else if (data_grant && fair_cnt != FW'(FAIR_MAX))   fair_cnt <= fair_cnt + 1'b1;

      drsp_valid <= data_grant;
      if (data_grant) drsp_data <= rom_data;
    end
  end
endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Directed scenarios plus randomized traffic checked every cycle against a queue-based model.
module tb_rom_fetch_arbiter;
  logic        clock = 1'b0;
  logic        reset_n;
  logic [9:0]  rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [9:0]  redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [9:0]  inst_pc;
  logic        dreq_valid;
  logic [9:0]  dreq_addr;
  logic        dreq_ready;
  logic        drsp_valid;
  logic [31:0] drsp_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] rom [256];
  assign rom_data = rom[rom_addr[9:2]];

  always #5 clock = ~clock;

  rom_fetch_arbiter dut (
    .clock(clock), .reset_n(reset_n), .rom_addr(rom_addr), .rom_data(rom_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_ready(dreq_ready),
    .drsp_valid(drsp_valid), .drsp_data(drsp_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the instruction queue is a plain list of (pc, word) pairs.
  typedef struct {
    logic [9:0]  pc;
    logic [31:0] w;
  } ent_t;
  ent_t        mq[$];
  logic [9:0]  m_pc;
  int          m_fair;
  logic        m_dv;
  logic [31:0] m_dd;

  always @(negedge clock) begin
    if (!reset_n) begin
      mq.delete();
      m_pc = 10'h000; m_fair = 0; m_dv = 1'b0; m_dd = 32'h0;
      check("rst_inst_valid", 32'(inst_valid), 32'd0);
      check("rst_drsp_valid", 32'(drsp_valid), 32'd0);
      check("rst_inst_pc", 32'(inst_pc), 32'd0);
      check("rst_inst_data", inst_data, 32'd0);
      check("rst_drsp_data", drsp_data, 32'd0);
    end else begin
      bit          hv, pop, can_fetch, dg, fg;
      logic [9:0]  addr;
      logic [31:0] word;
      hv        = (mq.size() > 0) && !redirect_valid;
      pop       = hv && inst_ready;
      can_fetch = !redirect_valid && (mq.size() < 2 || pop);
      dg        = dreq_valid && !(m_fair == 4 && can_fetch);
      fg        = !dg && can_fetch;
      addr      = dg ? (dreq_addr & 10'h3FC) : m_pc;
      word      = rom[addr[9:2]];
      check("m_inst_valid", 32'(inst_valid), 32'(hv));
      if (mq.size() > 0) begin
        check("m_inst_pc", 32'(inst_pc), 32'(mq[0].pc));
        check("m_inst_data", inst_data, mq[0].w);
      end
      check("m_dreq_ready", 32'(dreq_ready), 32'(dg));
      check("m_rom_addr", 32'(rom_addr), 32'(addr));
      check("m_drsp_valid", 32'(drsp_valid), 32'(m_dv));
      check("m_drsp_data", drsp_data, m_dd);
      if (pop) void'(mq.pop_front());
      if (fg) begin
        mq.push_back('{pc: m_pc, w: word});
        m_pc = m_pc + 10'd4;
      end
      if (redirect_valid) begin
        mq.delete();
        m_pc = redirect_pc & 10'h3FC;
      end
      m_dv = dg;
      if (dg) m_dd = word;
      if (!dreq_valid || fg) m_fair = 0;
      else if (dg && m_fair < 4) m_fair = m_fair + 1;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_head(input string name, input logic [9:0] pc, input logic [31:0] w);
    check({name, "_valid"}, 32'(inst_valid), 32'd1);
    check({name, "_pc"}, 32'(inst_pc), 32'(pc));
    check({name, "_data"}, inst_data, w);
  endtask

  logic [9:0]  img_pc [5];
  logic [31:0] img_w  [5];
  bit          exp_gnt [6];

  initial begin
    img_pc = '{10'h000, 10'h004, 10'h008, 10'h00C, 10'h010};
    img_w  = '{32'he0810002, 32'he0413000, 32'he2033010, 32'he1833001, 32'heafffffb};
    exp_gnt = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    for (int i = 0; i < 5; i++) rom[i] = img_w[i];

    reset_n = 1'b0; inst_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    dreq_valid = 1'b0; dreq_addr = '0;
    repeat (2) tick();

    // 1: straight-line fetch from reset
    reset_n = 1'b1;
    #1;
    check("t1_cycle0_addr", 32'(rom_addr), 32'h0);
    check("t1_cycle0_valid", 32'(inst_valid), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_head("t1", img_pc[i], img_w[i]);
    end

    // 3: redirect while pc 0x10 is at the head
    redirect_valid = 1'b1; redirect_pc = 10'h006;
    #1;
    check("t3_valid_forced0", 32'(inst_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check("t3_gap_valid", 32'(inst_valid), 32'd0);
    check("t3_fetch_addr", 32'(rom_addr), 32'h004);
    tick();
    expect_head("t3", 10'h004, 32'he0413000);

    // 2: consumer stalled from reset
    reset_n = 1'b0; inst_ready = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    check("t2_hold_addr", 32'(rom_addr), 32'h008);
    expect_head("t2_hold", 10'h000, 32'he0810002);
    inst_ready = 1'b1;
    #1;
    check("t2_release_addr", 32'(rom_addr), 32'h008);
    for (int i = 1; i < 4; i++) begin
      tick();
      expect_head("t2", img_pc[i], img_w[i]);
    end

    // 4: data burst with fairness slot
    for (int k = 0; k < 6; k++) begin
      dreq_valid = 1'b1; dreq_addr = 10'h009;
      #1;
      check("t4_dreq_ready", 32'(dreq_ready), 32'(exp_gnt[k]));
      if (exp_gnt[k]) check("t4_rom_addr", 32'(rom_addr), 32'h008);
      if (k > 0) begin
        check("t4_drsp_valid", 32'(drsp_valid), 32'(exp_gnt[k-1]));
        if (exp_gnt[k-1]) check("t4_drsp_data", drsp_data, 32'he2033010);
      end
      tick();
    end
    dreq_valid = 1'b0;
    #1;
    check("t4_last_drsp_valid", 32'(drsp_valid), 32'd1);
    check("t4_last_drsp_data", drsp_data, 32'he2033010);

    // 5: redirect to top of space, pc wraps
    redirect_valid = 1'b1; redirect_pc = 10'h3FC;
    tick();
    redirect_valid = 1'b0;
    tick();
    expect_head("t5_a", 10'h3FC, rom[255]);
    tick();
    expect_head("t5_b", 10'h000, 32'he0810002);
    tick();
    expect_head("t5_c", 10'h004, 32'he0413000);

    // 6: async reset with full queue and a response in flight
    inst_ready = 1'b0;
    repeat (3) tick();
    dreq_valid = 1'b1; dreq_addr = 10'h004;
    tick();
    dreq_valid = 1'b0;
    #1;
    check("t6_pre_drsp_valid", 32'(drsp_valid), 32'd1);
    check("t6_pre_drsp_data", drsp_data, 32'he0413000);
    check("t6_pre_inst_valid", 32'(inst_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    check("t6_rst_inst_valid", 32'(inst_valid), 32'd0);
    check("t6_rst_drsp_valid", 32'(drsp_valid), 32'd0);
    check("t6_rst_drsp_data", drsp_data, 32'd0);
    tick();
    inst_ready = 1'b1; reset_n = 1'b1;
    tick();
    expect_head("t6_restart", 10'h000, 32'he0810002);
    tick();
    expect_head("t6_restart2", 10'h004, 32'he0413000);

    // Randomized traffic; the negedge model checks every cycle.
    for (int n = 0; n < 3000; n++) begin
      inst_ready     = ($urandom_range(0, 3) != 0);
      dreq_valid     = ($urandom_range(0, 2) != 0);
      dreq_addr      = 10'($urandom);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = 10'($urandom);
      tick();
    end
    redirect_valid = 1'b0; dreq_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
